redmule_lane_splitter: RTL and testbench
========================================

REDMULE_LANE_SPLITTER -- requirements
Module: redmule_lane_splitter

Interface
REQ-001 SHALL have parameter MP, default 9: number of narrow lanes.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter LaneDW, default 32: lane data width. Lane byte stride SB = LaneDW/8.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port w_req_i, input, 1: wide request.
REQ-007 SHALL have port w_gnt_o, output, 1: wide grant.
REQ-008 SHALL have port w_add_i, input, AW: wide base byte address.
REQ-009 SHALL have port w_wen_i, input, 1: 1 = read, 0 = write.
REQ-010 SHALL have port w_be_i, input, MP*SB: byte enables.
REQ-011 SHALL have port w_data_i, input, MP*LaneDW: write data.
REQ-012 SHALL have port w_r_valid_o, output, 1: wide response valid.
REQ-013 SHALL have port w_r_data_o, output, MP*LaneDW: wide response data.
REQ-014 SHALL have port n_req_o, output, MP: per-lane request.
REQ-015 SHALL have port n_gnt_i, input, MP: per-lane grant.
REQ-016 SHALL have port n_add_o, output, MP*AW: per-lane address.
REQ-017 SHALL have ports n_wen_o (output, MP), n_be_o (output, MP*SB) and n_data_o (output, MP*LaneDW): per-lane request fields.
REQ-018 SHALL have ports n_r_valid_i (input, MP) and n_r_data_i (input, MP*LaneDW): per-lane response.
REQ-019 SHALL have port proto_err_o, output, 1: sticky error flag for an unexpected lane response.
REQ-020 SHALL have ports clr_cnt_i (input, 1) and stall_cnt_o (output, MP*32): stall counter clear and per-lane stall counts.

Function
REQ-021 SHALL drive lane i with: n_add_o[i] = (w_add_i + i*SB) mod 2^AW; n_be_o[i] = be slice i; n_data_o[i] = data slice i; n_wen_o[i] = w_wen_i. All are combinational.
REQ-022 SHALL implement an FSM with states IDLE, GRANT and RESP, plus per-lane registers gnt_mask[MP] and rsp_mask[MP].
REQ-023 IDLE with w_req_i=1: SHALL assert n_req_o on all lanes. If all lanes see n_gnt_i in that cycle, SHALL assert w_gnt_o=1 and go to RESP. Otherwise SHALL record the granted lanes in gnt_mask and go to GRANT.
REQ-024 GRANT: SHALL assert n_req_o only on lanes with gnt_mask=0. SHALL assert w_gnt_o=1 in the cycle where (gnt_mask|n_gnt_i) is all ones, then go to RESP. Upstream holds the w_* fields stable until w_gnt_o.
REQ-025 In any state, n_r_valid_i[i] on a lane with gnt_mask[i]=1 and rsp_mask[i]=0 SHALL set rsp_mask[i] and capture n_r_data_i[i]. A lane granted and responding in the same cycle is a protocol error.
REQ-026 RESP: SHALL assert w_r_valid_o=1 combinationally in the cycle where (rsp_mask|n_r_valid_i) is all ones. w_r_data_o lane i SHALL be the buffered data if rsp_mask[i]=1, else n_r_data_i[i]. On that cycle both masks SHALL clear.
REQ-027 The RESP completion cycle SHALL apply the IDLE request rule (REQ-023), so back-to-back transactions run at one per cycle when all lanes grant immediately and respond with 1-cycle latency.
REQ-028 w_r_valid_o SHALL NOT assert outside RESP. n_req_o SHALL be 0 in RESP except in the completion cycle.
REQ-029 Every transaction, read or write, SHALL produce exactly one w_r_valid_o pulse.
REQ-030 n_r_valid_i on a lane with no pending response SHALL be ignored and SHALL set proto_err_o, which stays 1 until reset.
REQ-031 A drop of w_req_i during GRANT SHALL NOT abort the transaction; remaining lanes keep requesting.

Reset
REQ-032 rst_n=0 at any time, including mid-transaction, SHALL force state to IDLE and clear gnt_mask, rsp_mask, all buffered data, proto_err_o and stall_cnt_o, with w_gnt_o, w_r_valid_o and n_req_o at 0. In-flight lane responses SHALL be discarded.

Configuration
REQ-033 With macro REDMULE_LANE_SPLITTER_STALL_CNT_EN defined: stall_cnt_o[i] SHALL increment, saturating at 2^32-1, in each cycle where n_req_o[i]=1 and n_gnt_i[i]=0. clr_cnt_i=1 SHALL zero all counters, taking priority over increment.
REQ-034 Without REDMULE_LANE_SPLITTER_STALL_CNT_EN: no counters SHALL be built, stall_cnt_o SHALL be tied to 0, and clr_cnt_i SHALL be ignored.

Verification
REQ-035 Read, w_add_i=0x1C010000, all 9 lanes grant immediately and respond 1 cycle later -> w_gnt_o in cycle 0, w_r_valid_o in cycle 1, n_add_o[8]=0x1C010020.
REQ-036 Lanes 0-3 granted in cycle 0 and lanes 4-8 in cycle 2 -> n_req_o=0x1F0 in cycles 1-2, w_gnt_o only in cycle 2, w_r_valid_o in cycle 3, data correctly assembled from buffered and live lanes.
REQ-037 Two back-to-back writes, zero stall -> 2 grants and 2 responses in consecutive cycles, with no idle bubble.
REQ-038 n_r_valid_i[5]=1 while IDLE -> proto_err_o=1 from the next cycle onward, w_r_valid_o stays 0.
REQ-039 With the macro defined, lane 2 withheld for 4 cycles -> stall_cnt_o[2]=4; clr_cnt_i pulse -> 0. rst_n pulse during GRANT -> IDLE, masks 0.
REQ-040 w_add_i=0xFFFFFFF0 -> n_add_o[8]=0x00000010 (wrap-around).

Source files
------------

// File: rtl/redmule_lane_splitter.sv
`default_nettype none
// ============================================================================
// Module      : redmule_lane_splitter
// Description : Splits one wide memory request into MP narrow lane requests
//               and merges the per-lane responses into one wide response.
//               Optional macro REDMULE_LANE_SPLITTER_STALL_CNT_EN adds
//               saturating per-lane stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_lane_splitter #(
    parameter int MP     = 9,
    parameter int AW     = 32,
    parameter int LaneDW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_req_i,
    output logic                     w_gnt_o,
    input  logic [AW-1:0]            w_add_i,
    input  logic                     w_wen_i,
    input  logic [MP*(LaneDW/8)-1:0] w_be_i,
    input  logic [MP*LaneDW-1:0]     w_data_i,
    output logic                     w_r_valid_o,
    output logic [MP*LaneDW-1:0]     w_r_data_o,
    output logic [MP-1:0]            n_req_o,
    input  logic [MP-1:0]            n_gnt_i,
    output logic [MP*AW-1:0]         n_add_o,
    output logic [MP-1:0]            n_wen_o,
    output logic [MP*(LaneDW/8)-1:0] n_be_o,
    output logic [MP*LaneDW-1:0]     n_data_o,
    input  logic [MP-1:0]            n_r_valid_i,
    input  logic [MP*LaneDW-1:0]     n_r_data_i,
    output logic                     proto_err_o,
    input  logic                     clr_cnt_i,
    output logic [MP*32-1:0]         stall_cnt_o
);
    localparam int            SB          = LaneDW / 8;
    localparam logic [MP-1:0] c_ALL_LANES = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [MP-1:0] r_gnt_mask;
    logic [MP-1:0] r_rsp_mask;
    logic          r_proto_err;
    logic [MP-1:0] w_gnt_acc;     // lanes accepting a request this cycle
    logic [MP-1:0] w_rsp_acc;     // lanes delivering an expected response
    logic [MP-1:0] w_rsp_bad;     // responses nobody is waiting for
    logic          w_done;        // wide response completes this cycle
    logic          w_accept_new;  // a new wide request may start this cycle

    // Request fields are shared by all lanes; only the address is offset.
    assign n_be_o   = w_be_i;
    assign n_data_o = w_data_i;
    assign n_wen_o  = {MP{w_wen_i}};

    assign w_rsp_acc   = n_r_valid_i & r_gnt_mask & ~r_rsp_mask;
    assign w_rsp_bad   = n_r_valid_i & ~(r_gnt_mask & ~r_rsp_mask);
    assign w_gnt_acc   = n_req_o & n_gnt_i;
    assign proto_err_o = r_proto_err;

    for (genvar i = 0; i < MP; i++) begin : g_lane
        localparam logic [AW-1:0] c_OFFSET = AW'(i * SB);
        logic [LaneDW-1:0] r_rsp_data;

        assign n_add_o[i*AW +: AW] = w_add_i + c_OFFSET;
        // Lanes that answered early come from the buffer, late ones pass through.
        assign w_r_data_o[i*LaneDW +: LaneDW] =
            r_rsp_mask[i] ? r_rsp_data : n_r_data_i[i*LaneDW +: LaneDW];

        // Hold an early lane response until the slowest lane has answered.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rsp_data <= '0;
            end else if (w_rsp_acc[i]) begin
                r_rsp_data <= n_r_data_i[i*LaneDW +: LaneDW];
            end
        end
    end

    // Advance the transaction state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; the completion cycle doubles as IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        n_req_o      = '0;
        w_gnt_o      = 1'b0;
        w_r_valid_o  = 1'b0;
        w_done       = 1'b0;
        w_accept_new = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept_new = 1'b1;
            end
            S_GRANT: begin
                n_req_o = ~r_gnt_mask;
                if ((r_gnt_mask | n_gnt_i) == c_ALL_LANES) begin
                    w_gnt_o     = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if ((r_rsp_mask | w_rsp_acc) == c_ALL_LANES) begin
                    w_r_valid_o  = 1'b1;
                    w_done       = 1'b1;
                    w_accept_new = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_accept_new && w_req_i) begin
            n_req_o = c_ALL_LANES;
            if (n_gnt_i == c_ALL_LANES) begin
                w_gnt_o     = 1'b1;
                w_state_nxt = S_RESP;
            end else begin
                w_state_nxt = S_GRANT;
            end
        end
        // Handshakes stay quiet for the whole reset assertion.
        if (!rst_n) begin
            n_req_o     = '0;
            w_gnt_o     = 1'b0;
            w_r_valid_o = 1'b0;
            w_done      = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // Track granted/answered lanes and latch any unexpected response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_mask  <= '0;
            r_rsp_mask  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_gnt_mask <= (w_done ? '0 : r_gnt_mask) | w_gnt_acc;
            r_rsp_mask <= w_done ? '0 : (r_rsp_mask | w_rsp_acc);
            if (|w_rsp_bad) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef REDMULE_LANE_SPLITTER_STALL_CNT_EN
    for (genvar i = 0; i < MP; i++) begin : g_stall
        logic [31:0] r_cnt;

        // Count cycles a lane is asked but withholds its grant; saturate.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (clr_cnt_i) begin
                r_cnt <= '0;
            end else if (n_req_o[i] && !n_gnt_i[i] && (r_cnt != 32'hFFFF_FFFF)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign stall_cnt_o[i*32 +: 32] = r_cnt;
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt_i;
    assign stall_cnt_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_redmule_lane_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_redmule_lane_splitter
// Description : Self-checking bench for redmule_lane_splitter: directed
//               scenarios plus a randomized run against a transaction-level
//               reference model of lanes and upstream requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_lane_splitter;
    localparam int MP = 9;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = DW / 8;
    localparam logic [MP-1:0] c_ALL = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_req_i;
    logic              w_gnt_o;
    logic [AW-1:0]     w_add_i;
    logic              w_wen_i;
    logic [MP*SB-1:0]  w_be_i;
    logic [MP*DW-1:0]  w_data_i;
    logic              w_r_valid_o;
    logic [MP*DW-1:0]  w_r_data_o;
    logic [MP-1:0]     n_req_o;
    logic [MP-1:0]     n_gnt_i;
    logic [MP*AW-1:0]  n_add_o;
    logic [MP-1:0]     n_wen_o;
    logic [MP*SB-1:0]  n_be_o;
    logic [MP*DW-1:0]  n_data_o;
    logic [MP-1:0]     n_r_valid_i;
    logic [MP*DW-1:0]  n_r_data_i;
    logic              proto_err_o;
    logic              clr_cnt_i;
    logic [MP*32-1:0]  stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    redmule_lane_splitter #(.MP(MP), .AW(AW), .LaneDW(DW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .w_req_i(w_req_i), .w_gnt_o(w_gnt_o), .w_add_i(w_add_i),
        .w_wen_i(w_wen_i), .w_be_i(w_be_i), .w_data_i(w_data_i),
        .w_r_valid_o(w_r_valid_o), .w_r_data_o(w_r_data_o),
        .n_req_o(n_req_o), .n_gnt_i(n_gnt_i), .n_add_o(n_add_o),
        .n_wen_o(n_wen_o), .n_be_o(n_be_o), .n_data_o(n_data_o),
        .n_r_valid_i(n_r_valid_i), .n_r_data_i(n_r_data_i),
        .proto_err_o(proto_err_o), .clr_cnt_i(clr_cnt_i),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [MP*AW-1:0] lane_addrs(input logic [AW-1:0] base);
        logic [MP*AW-1:0] v;
        logic [AW-1:0]    off;
        for (int i = 0; i < MP; i++) begin
            off = i * SB;
            v[i*AW +: AW] = base + off;
        end
        return v;
    endfunction

    function automatic logic [MP*DW-1:0] rand_wide();
        logic [MP*DW-1:0] v;
        for (int i = 0; i < MP; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic quiet_inputs();
        w_req_i = 0; n_gnt_i = '0; n_r_valid_i = '0; clr_cnt_i = 0;
    endtask

    // Reset with an active request and grants on the bus: everything must stay quiet.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; w_req_i = 1; n_gnt_i = '1; n_r_valid_i = '0;
        #1;
        check("rst_n_req", n_req_o, '0);
        check("rst_w_gnt", w_gnt_o, 0);
        check("rst_r_valid", w_r_valid_o, 0);
        check("rst_proto_err", proto_err_o, 0);
        check("rst_stall_cnt", stall_cnt_o, '0);
        @(negedge clk);
        quiet_inputs();
        rst_n = 1;
    endtask

    // ---------------- randomized reference model ----------------
    int               m_phase;      // 0 none, 1 collecting grants, 2 collecting responses
    logic [MP-1:0]    m_granted, m_deliv, m_pend;
    int               m_rem [MP];
    logic [MP*DW-1:0] m_exp_data;
    logic             m_up_valid;
    int               m_ngnt, m_nresp;

    task automatic run_cycle(input int req_pct, input int gnt_pct, input int lat_max);
        logic [MP-1:0] dn, ereq, newly;
        logic          egnt, evalid;
        @(negedge clk);
        n_r_valid_i = '0;
        n_r_data_i  = rand_wide();
        for (int i = 0; i < MP; i++) begin
            if (m_pend[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    n_r_valid_i[i] = 1'b1;
                    n_r_data_i[i*DW +: DW] = m_exp_data[i*DW +: DW];
                    m_pend[i] = 1'b0;
                end
            end
        end
        if (!m_up_valid && ($urandom_range(0, 99) < req_pct)) begin
            m_up_valid = 1;
            w_add_i  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 + $urandom_range(0, 31) : $urandom;
            w_wen_i  = $urandom_range(0, 1);
            w_be_i   = {$urandom, $urandom};
            w_data_i = rand_wide();
        end
        w_req_i = m_up_valid;
        if (m_phase == 1 && $urandom_range(0, 3) == 0) w_req_i = 0;
        for (int i = 0; i < MP; i++) n_gnt_i[i] = ($urandom_range(0, 99) < gnt_pct);
        #1;
        dn     = m_deliv | n_r_valid_i;
        evalid = (m_phase == 2) && (dn == c_ALL);
        if (m_phase == 1) begin
            ereq = ~m_granted;
            egnt = ((m_granted | n_gnt_i) == c_ALL);
        end else if ((m_phase == 0 || evalid) && w_req_i) begin
            ereq = c_ALL;
            egnt = (n_gnt_i == c_ALL);
        end else begin
            ereq = '0;
            egnt = 0;
        end
        check("rnd_n_req", n_req_o, ereq);
        check("rnd_w_gnt", w_gnt_o, egnt);
        check("rnd_r_valid", w_r_valid_o, evalid);
        check("rnd_n_add", n_add_o, lane_addrs(w_add_i));
        check("rnd_n_be", n_be_o, w_be_i);
        check("rnd_n_data", n_data_o, w_data_i);
        check("rnd_n_wen", n_wen_o, {MP{w_wen_i}});
        if (evalid) check("rnd_r_data", w_r_data_o, m_exp_data);
        newly   = ereq & n_gnt_i;
        m_deliv = evalid ? '0 : dn;
        for (int i = 0; i < MP; i++) begin
            if (newly[i]) begin
                m_pend[i] = 1;
                m_rem[i]  = $urandom_range(1, lat_max);
                m_exp_data[i*DW +: DW] = $urandom;
            end
        end
        if (m_phase == 1) begin
            m_granted = m_granted | newly;
            if (egnt) m_phase = 2;
        end else if (ereq == c_ALL) begin
            m_granted = newly;
            m_phase   = egnt ? 2 : 1;
        end else if (evalid) begin
            m_phase   = 0;
            m_granted = '0;
        end
        if (evalid) m_nresp++;
        if (egnt) begin
            m_ngnt++;
            m_up_valid = 0;
        end
    endtask

    logic [MP*DW-1:0] rd_a, rd_b, exp_d;
    logic [MP*32-1:0] exp_cnt;

    initial begin
        rst_n = 0; w_add_i = '0; w_wen_i = 0; w_be_i = '0; w_data_i = '0;
        n_r_data_i = '0;
        quiet_inputs();
        do_reset();

        // Read at 0x1C010000, all lanes grant at once, respond one cycle later.
        @(negedge clk);
        w_req_i = 1; w_add_i = 32'h1C01_0000; w_wen_i = 1; w_be_i = '1;
        w_data_i = rand_wide(); n_gnt_i = '1;
        #1;
        check("rd_gnt", w_gnt_o, 1);
        check("rd_n_req", n_req_o, c_ALL);
        check("rd_add8", n_add_o[8*AW +: AW], 32'h1C01_0020);
        check("rd_n_add", n_add_o, lane_addrs(32'h1C01_0000));
        check("rd_n_wen", n_wen_o, c_ALL);
        check("rd_r_valid0", w_r_valid_o, 0);
        rd_a = rand_wide();
        @(negedge clk);
        w_req_i = 0; n_gnt_i = '0; n_r_valid_i = '1; n_r_data_i = rd_a;
        #1;
        check("rd_r_valid1", w_r_valid_o, 1);
        check("rd_r_data", w_r_data_o, rd_a);
        check("rd_n_req_resp", n_req_o, '0);
        @(negedge clk);
        n_r_valid_i = '0;
        #1;
        check("rd_r_valid2", w_r_valid_o, 0);

        // Split grant: lanes 0-3 first, 4-8 two cycles later; request dropped meanwhile.
        @(negedge clk);
        w_req_i = 1; w_add_i = 32'h0000_1000; n_gnt_i = 9'h00F;
        #1;
        check("sp_n_req0", n_req_o, c_ALL);
        check("sp_gnt0", w_gnt_o, 0);
        rd_a = rand_wide();
        @(negedge clk);
        w_req_i = 0; n_gnt_i = '0; n_r_valid_i = 9'h00F; n_r_data_i = rd_a;
        #1;
        check("sp_n_req1", n_req_o, 9'h1F0);
        check("sp_gnt1", w_gnt_o, 0);
        @(negedge clk);
        n_gnt_i = 9'h1F0; n_r_valid_i = '0; n_r_data_i = rand_wide();
        #1;
        check("sp_n_req2", n_req_o, 9'h1F0);
        check("sp_gnt2", w_gnt_o, 1);
        check("sp_r_valid2", w_r_valid_o, 0);
        rd_b = rand_wide();
        @(negedge clk);
        n_gnt_i = '0; n_r_valid_i = 9'h1F0; n_r_data_i = rd_b;
        for (int i = 0; i < MP; i++)
            exp_d[i*DW +: DW] = (i < 4) ? rd_a[i*DW +: DW] : rd_b[i*DW +: DW];
        #1;
        check("sp_r_valid3", w_r_valid_o, 1);
        check("sp_r_data", w_r_data_o, exp_d);
        @(negedge clk);
        n_r_valid_i = '0;

        // Address wrap-around.
        w_add_i = 32'hFFFF_FFF0;
        #1;
        check("wrap_add8", n_add_o[8*AW +: AW], 32'h0000_0010);
        check("wrap_add3", n_add_o[3*AW +: AW], 32'hFFFF_FFFC);

        // Back-to-back writes without stall.
        @(negedge clk);
        w_req_i = 1; w_wen_i = 0; w_add_i = 32'h0000_2000; n_gnt_i = '1;
        #1;
        check("b2b_gnt0", w_gnt_o, 1);
        rd_a = rand_wide();
        @(negedge clk);
        w_add_i = 32'h0000_2040; n_r_valid_i = '1; n_r_data_i = rd_a;
        #1;
        check("b2b_valid1", w_r_valid_o, 1);
        check("b2b_gnt1", w_gnt_o, 1);
        check("b2b_n_req1", n_req_o, c_ALL);
        rd_b = rand_wide();
        @(negedge clk);
        w_req_i = 0; n_gnt_i = '0; n_r_data_i = rd_b;
        #1;
        check("b2b_valid2", w_r_valid_o, 1);
        check("b2b_data2", w_r_data_o, rd_b);
        @(negedge clk);
        n_r_valid_i = '0;
        #1;
        check("b2b_valid3", w_r_valid_o, 0);
        check("b2b_proto", proto_err_o, 0);

        // Stray response while idle.
        @(negedge clk);
        n_r_valid_i = 9'h020;
        #1;
        check("pe_valid0", w_r_valid_o, 0);
        check("pe_err0", proto_err_o, 0);
        @(negedge clk);
        n_r_valid_i = '0;
        #1;
        check("pe_err1", proto_err_o, 1);
        check("pe_valid1", w_r_valid_o, 0);
        repeat (3) @(negedge clk);
        #1;
        check("pe_sticky", proto_err_o, 1);
        do_reset();

        // Lane 2 withholds its grant for four cycles.
        @(negedge clk);
        w_req_i = 1; w_add_i = 32'h0000_3000; n_gnt_i = ~9'h004;
        #1;
        check("st_gnt0", w_gnt_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_gnt_i = '0;
            #1;
            check("st_n_req", n_req_o, 9'h004);
        end
        @(negedge clk);
        n_gnt_i = 9'h004;
        #1;
        check("st_gnt4", w_gnt_o, 1);
        @(negedge clk);
        w_req_i = 0; n_gnt_i = '0; n_r_valid_i = '1;
        #1;
        check("st_valid", w_r_valid_o, 1);
        exp_cnt = '0;
`ifdef REDMULE_LANE_SPLITTER_STALL_CNT_EN
        exp_cnt[2*32 +: 32] = 32'd4;
`endif
        check("st_cnt", stall_cnt_o, exp_cnt);
        @(negedge clk);
        n_r_valid_i = '0; clr_cnt_i = 1;
        @(negedge clk);
        clr_cnt_i = 0;
        #1;
        check("st_cnt_clr", stall_cnt_o, '0);

        // Reset in the middle of a grant phase discards the transaction.
        @(negedge clk);
        w_req_i = 1; w_add_i = 32'h0000_4000; n_gnt_i = 9'h00F;
        #1;
        check("rg_gnt0", w_gnt_o, 0);
        @(negedge clk);
        rst_n = 0; n_gnt_i = '1;
        #1;
        check("rg_n_req", n_req_o, '0);
        check("rg_gnt", w_gnt_o, 0);
        @(negedge clk);
        rst_n = 1; w_req_i = 0; n_gnt_i = '0; n_r_valid_i = 9'h001;
        #1;
        check("rg_valid", w_r_valid_o, 0);
        check("rg_n_req_idle", n_req_o, '0);
        @(negedge clk);
        n_r_valid_i = '0;
        #1;
        check("rg_stale_err", proto_err_o, 1);
        do_reset();

        // Randomized traffic against the transaction model.
        m_phase = 0; m_granted = '0; m_deliv = '0; m_pend = '0;
        m_up_valid = 0; m_ngnt = 0; m_nresp = 0; m_exp_data = '0;
        for (int i = 0; i < MP; i++) m_rem[i] = 0;
        for (int c = 0; c < 200; c++) run_cycle(100, 100, 1);
        for (int c = 0; c < 2000; c++) run_cycle(70, 60, 4);
        for (int c = 0; c < 60 && (m_phase != 0 || m_up_valid); c++) run_cycle(0, 100, 4);
        check("rnd_drained", m_phase, 0);
        check("rnd_resp_count", m_nresp, m_ngnt);
        check("rnd_proto", proto_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
